alu_control_pipe: RTL and testbench
===================================

Name: alu_control_pipe

Overview:
Registered, parametrised successor to the combinational ALU control decoder. It accepts ALUop/funct pairs from the control unit over a valid/ready handshake and decodes them into a widened ALU control code plus JR and illegal-op flags. Results are presented from an output register with one-cycle latency. It also sequences multi-cycle mult/div operations by holding off new inputs for a fixed busy period. It sits between the Control Unit/ID stage and the EX-stage ALU.

Parameters:
ALUOP_W, 3, ALUop width (value >= 3)
FUNCT_W, 6, funct field width
CTRL_W, 4, ALU control code width (value >= 4)
MD_LAT, 4, busy cycles after a mult/div is accepted (value >= 1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  alu_op/funct valid
in_ready  out  1  block can accept this cycle
alu_op  in  ALUOP_W  ALUop from Control Unit
funct  in  FUNCT_W  instruction funct field
out_valid  out  1  output register holds a result
out_ready  in  1  EX stage consumes the result
alu_ctrl  out  CTRL_W  decoded ALU control code
jr_ctrl  out  1  instruction is JR
illegal  out  1  undefined ALUop/funct combination
md_busy  out  1  mult/div in progress

Behaviour:
- Reset (async, rst_n=0): out_valid=0, alu_ctrl=0, jr_ctrl=0, illegal=0, md_busy=0, busy counter=0. in_ready is 1 one cycle after release.
- in_ready = !md_busy && (!out_valid || out_ready). This is combinational; there is no in_valid->in_ready path.
- Accept = in_valid && in_ready. On accept, the decode is registered and out_valid=1 on the next edge, giving a latency of 1 cycle.
- If out_valid && out_ready && !accept, out_valid clears. If out_valid && !out_ready, all outputs hold stable.
- ALUop decode:
  - 000 -> ADD (0): lw/sw.
  - 001 -> SUB (1): beq.
  - 010 -> ADD: addi.
  - 011 -> SUB: subi.
  - 100 -> R-type, decoded by funct.
  - 101..111 -> illegal=1, alu_ctrl=NOP (15).
- R-type funct decode:
  - 100000 -> ADD 0
  - 100010 -> SUB 1
  - 100110 -> XOR 2
  - 100100 -> AND 3
  - 100101 -> OR 4
  - 101010 -> SLT 5
  - 000000 -> SLL 6
  - 000010 -> SRL 7
  - 011000 -> MULT 8
  - 011010 -> DIV 9
  - 001000 -> JR: jr_ctrl=1, alu_ctrl=ADD
  - any other -> illegal=1, alu_ctrl=NOP
- jr_ctrl is asserted only for ALUop=100 with funct=001000. The earlier 2-bit {op,funct} comparison is not used.
- Mult/div state machine, states IDLE and BUSY:
  - IDLE -> BUSY on accept of MULT or DIV. The counter loads MD_LAT and md_busy=1 from the next edge.
  - In BUSY the counter decrements each cycle. BUSY -> IDLE when the counter goes 1 -> 0; md_busy is then 0 on the following cycle.
  - md_busy stays high for exactly MD_LAT cycles. The result itself is still presented with out_valid after 1 cycle.
  - A back-to-back mult is only accepted after md_busy falls.
- Illegal decodes still complete the handshake (out_valid=1, illegal=1). Flushing is handled by the consumer.
- Reset mid-BUSY: the counter and md_busy clear immediately; any pending output is dropped.
- Unused high bits: funct is compared over all FUNCT_W bits, zero-extended table constants. alu_ctrl codes are zero-extended to CTRL_W.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU code localparams ADD..DIV, NOP=15
  - ALUop encodings
  - funct constants
  - function decode(alu_op, funct) returning {illegal, jr, code}
- One sub-module, alu_ctrl_decode: a pure combinational decode table. The top level holds the output register, handshake and mult/div counter.

Test Plan:
1. Reset, then alu_op=100 funct=100110 in_valid=1 out_ready=1 -> next cycle out_valid=1, alu_ctrl=2, jr_ctrl=0, illegal=0.
2. Stream 000, 001, 011 with out_ready=1 on consecutive cycles -> alu_ctrl 0, 1, 1 on consecutive cycles, in_ready constant 1.
3. alu_op=100 funct=011000 with MD_LAT=4 -> alu_ctrl=8 after 1 cycle; md_busy=1 and in_ready=0 for exactly 4 cycles; a second MULT held on input is accepted on cycle 5.
4. out_ready=0 for 3 cycles with out_valid=1 -> alu_ctrl held, in_ready=0; out_ready=1 -> the next input is accepted in the same cycle.
5. alu_op=110, then 100/funct=111111 -> illegal=1, alu_ctrl=15 for both; alu_op=100 funct=001000 -> jr_ctrl=1, alu_ctrl=0.
6. Assert rst_n=0 during BUSY at count 2 -> md_busy and out_valid drop asynchronously to 0; after release in_ready=1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and the reference decode table for the ALU control pipeline.
// Operand widths are fixed at 32 bits here so one function serves any module parametrisation.
package alu_ctrl_pkg;

  localparam int CODE_W = 4;
  localparam int CMP_W  = 32;

  localparam logic [CODE_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [CODE_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [CODE_W-1:0] ALU_XOR  = 4'd2;
  localparam logic [CODE_W-1:0] ALU_AND  = 4'd3;
  localparam logic [CODE_W-1:0] ALU_OR   = 4'd4;
  localparam logic [CODE_W-1:0] ALU_SLT  = 4'd5;
  localparam logic [CODE_W-1:0] ALU_SLL  = 4'd6;
  localparam logic [CODE_W-1:0] ALU_SRL  = 4'd7;
  localparam logic [CODE_W-1:0] ALU_MULT = 4'd8;
  localparam logic [CODE_W-1:0] ALU_DIV  = 4'd9;
  localparam logic [CODE_W-1:0] ALU_NOP  = 4'd15;

  localparam logic [2:0] OP_LWSW  = 3'b000;
  localparam logic [2:0] OP_BEQ   = 3'b001;
  localparam logic [2:0] OP_ADDI  = 3'b010;
  localparam logic [2:0] OP_SUBI  = 3'b011;
  localparam logic [2:0] OP_RTYPE = 3'b100;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_JR   = 6'b001000;

  typedef struct packed {
    logic              illegal;
    logic              jr;
    logic [CODE_W-1:0] code;
  } dec_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Inputs arrive zero-extended, so any set high bit falls through to the illegal default.
  function automatic dec_t decode(input logic [CMP_W-1:0] alu_op,
                                  input logic [CMP_W-1:0] funct);
    dec_t d;
    d = '{illegal: 1'b0, jr: 1'b0, code: ALU_ADD};
    case (alu_op)
      CMP_W'(OP_LWSW),
      CMP_W'(OP_ADDI):  d.code = ALU_ADD;
      CMP_W'(OP_BEQ),
      CMP_W'(OP_SUBI):  d.code = ALU_SUB;
      CMP_W'(OP_RTYPE): begin
        case (funct)
          CMP_W'(F_ADD):  d.code = ALU_ADD;
          CMP_W'(F_SUB):  d.code = ALU_SUB;
          CMP_W'(F_XOR):  d.code = ALU_XOR;
          CMP_W'(F_AND):  d.code = ALU_AND;
          CMP_W'(F_OR):   d.code = ALU_OR;
          CMP_W'(F_SLT):  d.code = ALU_SLT;
          CMP_W'(F_SLL):  d.code = ALU_SLL;
          CMP_W'(F_SRL):  d.code = ALU_SRL;
          CMP_W'(F_MULT): d.code = ALU_MULT;
          CMP_W'(F_DIV):  d.code = ALU_DIV;
          CMP_W'(F_JR): begin
            d.code = ALU_ADD;
            d.jr   = 1'b1;
          end
          default: begin
            d.code    = ALU_NOP;
            d.illegal = 1'b1;
          end
        endcase
      end
      default: begin
        d.code    = ALU_NOP;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational ALUop/funct decode; adapts module widths to the package table.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 4
) (
  input  logic [ALUOP_W-1:0] alu_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [CTRL_W-1:0]  code_o,
  output logic               jr_o,
  output logic               illegal_o,
  output logic               is_md_o
);

  dec_t dec;

  assign dec       = decode(CMP_W'(alu_op_i), CMP_W'(funct_i));
  assign code_o    = CTRL_W'(dec.code);
  assign jr_o      = dec.jr;
  assign illegal_o = dec.illegal;
  assign is_md_o   = !dec.illegal && (dec.code == ALU_MULT || dec.code == ALU_DIV);

endmodule

// File: rtl/alu_control_pipe.sv
// Registered ALU control decoder with valid/ready handshake and a fixed-latency
// mult/div busy window that holds off new inputs.
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 4,
  parameter int MD_LAT  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               jr_ctrl,
  output logic               illegal,
  output logic               md_busy
);

  localparam int CNT_W = $clog2(MD_LAT + 1);

  logic [CTRL_W-1:0] dec_code;
  logic              dec_jr;
  logic              dec_illegal;
  logic              dec_is_md;
  logic              accept;

  logic              out_valid_d, out_valid_q;
  logic [CTRL_W-1:0] alu_ctrl_d,  alu_ctrl_q;
  logic              jr_d,        jr_q;
  logic              illegal_d,   illegal_q;

  md_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              md_busy_q;

  alu_ctrl_decode #(
    .ALUOP_W (ALUOP_W),
    .FUNCT_W (FUNCT_W),
    .CTRL_W  (CTRL_W)
  ) u_decode (
    .alu_op_i  (alu_op),
    .funct_i   (funct),
    .code_o    (dec_code),
    .jr_o      (dec_jr),
    .illegal_o (dec_illegal),
    .is_md_o   (dec_is_md)
  );

  assign in_ready = !md_busy_q && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: every always_comb target gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    out_valid_d = out_valid_q;
    alu_ctrl_d  = alu_ctrl_q;
    jr_d        = jr_q;
    illegal_d   = illegal_q;
    if (accept) begin
      out_valid_d = 1'b1;
      alu_ctrl_d  = dec_code;
      jr_d        = dec_jr;
      illegal_d   = dec_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= '0;
      jr_q        <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_ctrl_q  <= alu_ctrl_d;
      jr_q        <= jr_d;
      illegal_q   <= illegal_d;
    end
  end

  // The busy window counts MD_LAT edges after the accepting edge; md_busy is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (accept && dec_is_md) begin
            state_q   <= MD_BUSY;
            cnt_q     <= CNT_W'(MD_LAT);
            md_busy_q <= 1'b1;
          end
        end
        MD_BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q   <= MD_IDLE;
            md_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= MD_IDLE;
          cnt_q     <= '0;
          md_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign jr_ctrl   = jr_q;
  assign illegal   = illegal_q;
  assign md_busy   = md_busy_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed bench for alu_control_pipe: a decode vector table streamed back-to-back,
// plus hand sequences for mult/div busy, backpressure and reset during busy.
module tb_alu_control_pipe;

  localparam int ALUOP_W = 3;
  localparam int FUNCT_W = 6;
  localparam int CTRL_W  = 4;
  localparam int MD_LAT  = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [ALUOP_W-1:0] alu_op;
  logic [FUNCT_W-1:0] funct;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  alu_ctrl;
  logic               jr_ctrl;
  logic               illegal;
  logic               md_busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] ctrl;
    logic       jr;
    logic       ill;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  alu_control_pipe #(
    .ALUOP_W (ALUOP_W),
    .FUNCT_W (FUNCT_W),
    .CTRL_W  (CTRL_W),
    .MD_LAT  (MD_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .jr_ctrl   (jr_ctrl),
    .illegal   (illegal),
    .md_busy   (md_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Test plan 1 first, then the stream of plan 2, then plan 5 and the remaining table.
    vecs[0]  = '{3'b100, 6'b100110, 4'd2,  1'b0, 1'b0};
    vecs[1]  = '{3'b000, 6'b111111, 4'd0,  1'b0, 1'b0};
    vecs[2]  = '{3'b001, 6'b000000, 4'd1,  1'b0, 1'b0};
    vecs[3]  = '{3'b011, 6'b101010, 4'd1,  1'b0, 1'b0};
    vecs[4]  = '{3'b010, 6'b001000, 4'd0,  1'b0, 1'b0};
    vecs[5]  = '{3'b110, 6'b100000, 4'd15, 1'b0, 1'b1};
    vecs[6]  = '{3'b100, 6'b111111, 4'd15, 1'b0, 1'b1};
    vecs[7]  = '{3'b100, 6'b001000, 4'd0,  1'b1, 1'b0};
    vecs[8]  = '{3'b100, 6'b100000, 4'd0,  1'b0, 1'b0};
    vecs[9]  = '{3'b100, 6'b100010, 4'd1,  1'b0, 1'b0};
    vecs[10] = '{3'b100, 6'b100100, 4'd3,  1'b0, 1'b0};
    vecs[11] = '{3'b100, 6'b100101, 4'd4,  1'b0, 1'b0};
    vecs[12] = '{3'b100, 6'b101010, 4'd5,  1'b0, 1'b0};
    vecs[13] = '{3'b100, 6'b000000, 4'd6,  1'b0, 1'b0};
    vecs[14] = '{3'b100, 6'b000010, 4'd7,  1'b0, 1'b0};
    vecs[15] = '{3'b101, 6'b100000, 4'd15, 1'b0, 1'b1};
    vecs[16] = '{3'b111, 6'b100000, 4'd15, 1'b0, 1'b1};
    vecs[17] = '{3'b100, 6'b000001, 4'd15, 1'b0, 1'b1};
    vecs[18] = '{3'b100, 6'b001001, 4'd15, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_op    = '0;
    funct     = '0;
    out_ready = 1'b1;

    // Reset state
    #2;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst alu_ctrl",  32'(alu_ctrl),  32'd0);
    check("rst jr_ctrl",   32'(jr_ctrl),   32'd0);
    check("rst illegal",   32'(illegal),   32'd0);
    check("rst md_busy",   32'(md_busy),   32'd0);
    #10 rst_n = 1'b1;
    tick();
    check("post-rst in_ready", 32'(in_ready), 32'd1);

    // Decode table streamed back-to-back with out_ready high
    for (int i = 0; i < NVEC; i++) begin
      alu_op   = vecs[i].op;
      funct    = vecs[i].fn;
      in_valid = 1'b1;
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d alu_ctrl", i),  32'(alu_ctrl),  32'(vecs[i].ctrl));
      check($sformatf("vec%0d jr_ctrl", i),   32'(jr_ctrl),   32'(vecs[i].jr));
      check($sformatf("vec%0d illegal", i),   32'(illegal),   32'(vecs[i].ill));
    end
    in_valid = 1'b0;
    tick();
    check("drain out_valid", 32'(out_valid), 32'd0);

    // MULT: busy for exactly MD_LAT cycles, second MULT held then accepted
    alu_op   = 3'b100;
    funct    = 6'b011000;
    in_valid = 1'b1;
    tick();
    check("mult out_valid", 32'(out_valid), 32'd1);
    check("mult alu_ctrl",  32'(alu_ctrl),  32'd8);
    check("mult busy c1",   32'(md_busy),   32'd1);
    check("mult ready c1",  32'(in_ready),  32'd0);
    for (int k = 2; k <= MD_LAT; k++) begin
      tick();
      check($sformatf("mult busy c%0d", k),  32'(md_busy),   32'd1);
      check($sformatf("mult ready c%0d", k), 32'(in_ready),  32'd0);
      check($sformatf("mult ov c%0d", k),    32'(out_valid), 32'd0);
    end
    tick();
    check("mult busy end",  32'(md_busy),  32'd0);
    check("mult ready end", 32'(in_ready), 32'd1);
    tick();
    check("mult2 out_valid", 32'(out_valid), 32'd1);
    check("mult2 alu_ctrl",  32'(alu_ctrl),  32'd8);
    check("mult2 busy",      32'(md_busy),   32'd1);
    in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (md_busy && n < 20) begin
        tick();
        n++;
      end
      check("mult2 busy released", 32'(md_busy), 32'd0);
    end

    // Backpressure: outputs hold while out_ready is low
    alu_op   = 3'b100;
    funct    = 6'b100101;
    in_valid = 1'b1;
    tick();
    check("bp first alu_ctrl", 32'(alu_ctrl), 32'd4);
    out_ready = 1'b0;
    alu_op    = 3'b001;
    funct     = 6'b000000;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp ready hold%0d", k), 32'(in_ready), 32'd0);
      tick();
      check($sformatf("bp ov hold%0d", k),   32'(out_valid), 32'd1);
      check($sformatf("bp ctrl hold%0d", k), 32'(alu_ctrl),  32'd4);
    end
    out_ready = 1'b1;
    #1;
    check("bp ready release", 32'(in_ready), 32'd1);
    tick();
    check("bp next out_valid", 32'(out_valid), 32'd1);
    check("bp next alu_ctrl",  32'(alu_ctrl),  32'd1);
    in_valid = 1'b0;
    tick();
    check("bp drain out_valid", 32'(out_valid), 32'd0);

    // Reset during BUSY at count 2, with an output still pending
    alu_op   = 3'b100;
    funct    = 6'b011010;
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("div alu_ctrl", 32'(alu_ctrl), 32'd9);
    check("div busy",     32'(md_busy),  32'd1);
    tick();
    tick();
    check("div busy pre-rst", 32'(md_busy),   32'd1);
    check("div ov pre-rst",   32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid-rst md_busy",   32'(md_busy),   32'd0);
    check("mid-rst out_valid", 32'(out_valid), 32'd0);
    check("mid-rst alu_ctrl",  32'(alu_ctrl),  32'd0);
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    check("after-rst in_ready",  32'(in_ready),  32'd1);
    check("after-rst md_busy",   32'(md_busy),   32'd0);
    check("after-rst out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
